// File: rtl/srambank_pkg.sv
// Shared types and elaboration helpers for the multi-bank SRAM.
package srambank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/srambank_multi_if.sv
// Request/response bundle between a memory client and srambank_multi.
interface srambank_multi_if #(
   parameter int WIDTH = 18,
   parameter int LANES = 2,
   parameter int AW    = 9
);
   logic [AW-1:0]    address;
   logic [WIDTH-1:0] wd;
   logic [LANES-1:0] wmask;
   logic             banksel;
   logic             read;
   logic             write;
   logic             clear;
   logic             busy;
   logic [WIDTH-1:0] dataout;
   logic             rvalid;
   logic             err;

   modport master (
      output address, wd, wmask, banksel, read, write, clear,
      input  busy, dataout, rvalid, err
   );

   modport slave (
      input  address, wd, wmask, banksel, read, write, clear,
      output busy, dataout, rvalid, err
   );
endinterface

// File: rtl/srambank_array.sv
// Storage only: lane-masked write port and a registered read port.
module srambank_array
   import srambank_pkg::*;
#(
   parameter int WIDTH  = 18,
   parameter int DEPTH  = 512,
   parameter int LANE_W = 9,
   parameter int LANES  = WIDTH / LANE_W,
   parameter int AW     = addr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [LANES-1:0] wmask,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (wmask[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
         end
      end
   end

   // Only the read register is reset; the array itself stays unknown until written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/srambank_multi.sv
// SRAM bank top: access arbitration, clear engine, output pipeline, sticky error.
//  state | meaning
//  IDLE  | accepting reads/writes, clear sampled here
//  CLEAR | zeroing word cnt each cycle, all accesses dropped
module srambank_multi
   import srambank_pkg::*;
#(
   parameter int WIDTH   = 18,
   parameter int ROWS    = 128,
   parameter int NBANKS  = 4,
   parameter int LANE_W  = 9,
   parameter int OUT_REG = 0
) (
   input logic              clk,
   input logic              rst_n,
   srambank_multi_if.slave  bus
);
   localparam int DEPTH = ROWS * NBANKS;
   localparam int LANES = WIDTH / LANE_W;
   localparam int AW    = addr_w(DEPTH);

   if (!is_pow2(ROWS))        begin : g_chk_rows  $error("ROWS must be a power of two");   end
   if (!is_pow2(NBANKS))      begin : g_chk_banks $error("NBANKS must be a power of two"); end
   if (WIDTH % LANE_W != 0)   begin : g_chk_lane  $error("WIDTH must be a multiple of LANE_W"); end

   state_t           state;
   logic [AW-1:0]    cnt;
   logic             busy_q;
   logic             err_q;
   logic             v1;
   logic             req, acc, rd_ok, wr_ok, err_set;
   logic             arr_we;
   logic [AW-1:0]    arr_waddr;
   logic [WIDTH-1:0] arr_wdata;
   logic [LANES-1:0] arr_wmask;
   logic [WIDTH-1:0] arr_rdata;

   always_comb begin
      req     = bus.banksel & (bus.read | bus.write);
      acc     = req & ~busy_q;
      rd_ok   = acc & bus.read & ~bus.write;
      wr_ok   = acc & bus.write;
      err_set = req & (busy_q | (bus.read & bus.write));
      arr_we    = (state == CLEAR) | wr_ok;
      arr_waddr = (state == CLEAR) ? cnt : bus.address;
      arr_wdata = (state == CLEAR) ? '0 : bus.wd;
      arr_wmask = (state == CLEAR) ? '1 : bus.wmask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.clear) begin
                  state  <= CLEAR;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (cnt == AW'(DEPTH - 1)) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         v1    <= 1'b0;
      end else begin
         err_q <= err_q | err_set;
         v1    <= rd_ok;
      end
   end

   srambank_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LANE_W(LANE_W),
      .LANES (LANES),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .wmask (arr_wmask),
      .re    (rd_ok),
      .raddr (bus.address),
      .rdata (arr_rdata)
   );

   if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] dout_q;
      logic             rv_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_q <= '0;
            rv_q   <= 1'b0;
         end else begin
            if (v1) dout_q <= arr_rdata;
            rv_q <= v1;
         end
      end
      assign bus.dataout = dout_q;
      assign bus.rvalid  = rv_q;
   end else begin : g_noreg
      assign bus.dataout = arr_rdata;
      assign bus.rvalid  = v1;
   end

   assign bus.busy = busy_q;
   assign bus.err  = err_q;
endmodule

// File: doc/srambank_multi.md
# srambank_multi

Parametrised synchronous single-port SRAM bank: NBANKS sub-banks of ROWS words each, WIDTH bits per word, with per-lane write masking, a registered read path with valid strobe, an optional second output register, and a built-in clear engine that zeroes the whole array. It is the generalised successor to the fixed 128x4x18 bank and is instantiated wherever a macro-backed scratch memory needs masking, zero-initialisation or error reporting.

## Interface
- WIDTH, 18, data word width in bits
- ROWS, 128, words per sub-bank (power of two)
- NBANKS, 4, sub-banks (power of two); total DEPTH = ROWS*NBANKS
- LANE_W, 9, write-mask granularity; WIDTH must be a multiple of LANE_W; LANES = WIDTH/LANE_W
- OUT_REG, 0, 1 adds a second output pipeline stage
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- address  in  AW=clog2(DEPTH)  word address, {bank, row}
- wd  in  WIDTH  write data
- wmask  in  LANES  per-lane write enable, 1 = write lane
- banksel  in  1  access enable
- read  in  1  read request
- write  in  1  write request
- clear  in  1  start clear engine (sampled when idle)
- busy  out  1  clear engine running
- dataout  out  WIDTH  read data, held until next valid read
- rvalid  out  1  one-cycle strobe marking new dataout
- err  out  1  sticky error flag

## Operation
- Access accepted when banksel & (read | write) & !busy.
- Write: lanes with wmask[i]=1 take wd[i*LANE_W +: LANE_W]; other lanes unchanged. wmask=0 is a legal no-op write.
- Read: returns memory word as it was before any same-cycle write.
- Read & write together (with banksel): write performed, read dropped, no rvalid, err set.
- Access while busy: dropped entirely, err set.
- Clear engine FSM: IDLE -> CLEAR on clear=1 in IDLE; CLEAR writes zero, full mask, to address cnt, cnt 0..DEPTH-1, one word/cycle; after writing DEPTH-1 -> IDLE. clear asserted while in CLEAR is ignored. clear and an access in the same IDLE cycle: access performed, clear starts next cycle.
- err cleared only by reset.
- Memory array is not reset; contents undefined until written or cleared.
- Reset mid-clear: FSM to IDLE, cnt to 0, array partially cleared (undefined).

## Timing
- Reset values: dataout=0, rvalid=0, err=0, busy=0, FSM=IDLE, cnt=0.
- Read latency: OUT_REG=0 -> dataout/rvalid update on edge after request (1 cycle); OUT_REG=1 -> 2 cycles. Back-to-back reads every cycle at full throughput.
- Write visible to a read issued on the following cycle.
- busy rises on the edge that samples clear in IDLE, stays high exactly DEPTH cycles, falls on the edge after the final zero write; first access accepted the cycle busy is low.
- err rises on the edge sampling the offending request.

## Structure
- Package srambank_pkg: state enum (IDLE, CLEAR), clog2-based width helpers, parameter legality checks (power-of-two ROWS/NBANKS, WIDTH % LANE_W == 0) as elaboration assertions.
- Sub-module srambank_array: pure storage, DEPTH x WIDTH, single write port with lane mask plus synchronous read port; top level holds arbitration, clear FSM, output pipeline and err.

## Test plan
- Reset then write 0x2AAAA to address 0x1FF, read 0x1FF -> dataout=0x2AAAA with rvalid one cycle later (two with OUT_REG=1), dataout held after rvalid drops.
- Write 0x3FFFF to 0x005, then write 0x00000 with wmask=2'b01 -> read 0x005 returns 0x3FE00.
- read & write & banksel to 0x010 with wd=0x12345 -> no rvalid, err=1 sticky; subsequent read of 0x010 returns 0x12345.
- Fill array with nonzero, pulse clear -> busy high exactly 512 cycles; read during busy dropped and err=1; afterwards reads of 0x000, 0x17F, 0x1FF return 0.
- Assert rst_n low mid-clear (cycle 100) -> busy, rvalid, err, dataout all 0 immediately; new clear after release completes in 512 cycles.
- Streaming reads of 0..15 every cycle -> 16 consecutive rvalid strobes with matching data in order; banksel=0 requests produce no rvalid.
